bcd_display: RTL and testbench
==============================

# bcd_display

Output stage that sits directly downstream of the ALU's 16-bit result bus. It captures a 16-bit unsigned binary value on a load handshake and converts it to BCD with a sequential double-dabble engine, one bit per clock. It then drives a 4-digit, time-multiplexed, common-anode 7-segment display, flagging values above 9999 as overflow.

## Interface
- CLK_DIV, default 50000: prescaler period in clk cycles per digit slot. Legal range ≥ 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset: synchronous, active-low.
- in  in  16  unsigned binary value to display (ALU `out`).
- load  in  1  capture request; accepted only on an edge where ready=1.
- ready  out  1  high when idle and able to accept load.
- ovf  out  1  high when the displayed value exceeds 9999.
- an  out  4  digit enables, active-low, one-hot; an[0] is the least-significant digit.
- sseg  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states:
  - IDLE: ready=1.
  - CONV: ready=0; a 5-bit iteration counter runs 0..15.
- IDLE→CONV on an edge with load=1:
  - Latch in into a 16-bit shift register.
  - Clear the 20-bit BCD scratch (5 digits) and the counter.
- CONV, each edge:
  - Add 3 to every scratch nibble ≥ 5.
  - Shift {scratch, shift register} left by 1.
- CONV→IDLE on the edge where the counter is 15. On that edge:
  - Write scratch[15:0] to the 4-digit display register.
  - Set ovf = (scratch[19:16] != 0).
  - Set ready=1.
- load while ready=0 is ignored; there is no queueing.
- Scan, running continuously and independent of the FSM:
  - Prescaler counts 0..CLK_DIV-1 and wraps.
  - On wrap, the digit index increments mod 4 (0→1→2→3→0).
  - an = ~(4'b0001 << index).
  - sseg = decode(display digit[index]).
- Decode: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000.
- Nibbles 10–15 cannot occur. If one does, the decoder outputs blank (1111111).
- When ovf=1, every digit shows dash (0111111) regardless of the display register.

## Timing
- Reset values:
  - ready=1, ovf=0.
  - Display register = 0000.
  - Prescaler=0, index=0.
  - an=1110, sseg=1000000.
- Latency: ready is low for exactly 16 cycles after the accepting edge. The new value appears on the next cycle, with ready=1 in that same cycle.
- The display register is stable throughout CONV, so the old value keeps being shown.
- A load coincident with the final CONV edge is ignored, because ready=0 on that edge.
- rst low mid-conversion:
  - Abort the conversion and restore all reset values on that edge.
  - The partial result is discarded.
- Outputs an and sseg are registered or derived from registered state only, and are glitch-free at the digit change.
- Boundary values: in=0 displays 0000; in=9999 gives ovf=0; in=10000 through 65535 gives ovf=1.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: digits 3..1 show blank (1111111) while they and every more-significant digit are zero. Digit 0 is always shown, and an still scans all four digits. Has no effect when ovf=1.
  - Undefined: all four digits always show their value, including leading zeros.

## Structure
- Shared package `bcd_display_pkg` contains:
  - State enum {IDLE, CONV}.
  - NUM_DIGITS=4 and SCRATCH_DIGITS=5.
  - Segment constants SEG_BLANK=7'b1111111 and SEG_DASH=7'b0111111.
  - The 10-entry digit-to-segment table.
- One sub-module, `seg7_decode`: combinational 4-bit BCD → 7-bit active-low segments, blank on 10–15.
- Converter FSM, display register and scan counter live in the top.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release → ready=1, ovf=0, an=1110, sseg=1000000. With CLK_DIV=4, an cycles 1110→1101→1011→0111 every 4 clocks.
- Normal conversion: load with in=1234 → ready=0 for 16 cycles, then 1. The scan then shows an=1110/sseg=0011001, 1101/0110000, 1011/0100100, 0111/1111001, with ovf=0.
- Upper edge: in=9999 → all digits 0010000, ovf=0. In=10000 → ovf=1 and all digits 0111111. In=65535 → ovf=1.
- Busy load ignored: load in=42, then pulse load with in=7 on cycle 5 of CONV → final display is 0042 and ready timing is unchanged.
- Reset mid-conversion: load in=1234, assert rst=0 on cycle 8 → next cycle ready=1, display 0000, an=1110. A subsequent load with in=5 displays 0005.
- LEADING_ZERO_BLANK_EN defined, in=42 → digits 3 and 2 show 1111111, digit 1 shows 0011001, digit 0 shows 0100100. In=0 → digit 0 shows 1000000 and the others are blank.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared types, sizes and segment encodings for bcd_display
package bcd_display_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int NUM_DIGITS     = 4;
    localparam int SCRATCH_DIGITS = 5;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}; entry i is the pattern for decimal digit i
    localparam logic [0:9][6:0] SEG_TABLE = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/bcd_display_if.sv
// rtl/bcd_display_if.sv - load handshake and display pins of bcd_display
interface bcd_display_if;
    logic [15:0] in;
    logic        load;
    logic        ready;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  sseg;

    modport master (
        output in, load,
        input  ready, ovf, an, sseg
    );

    modport slave (
        input  in, load,
        output ready, ovf, an, sseg
    );
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit BCD digit to active-low 7-segment pattern, blank on 10-15
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == 4'(i)) begin
                seg = SEG_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/bcd_display.sv
// rtl/bcd_display.sv - double-dabble converter and 4-digit multiplexed display driver
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_display
    import bcd_display_pkg::*;
#(
    parameter int CLK_DIV = 50000
)
(
    input  logic            clk,
    input  logic            rst,
    bcd_display_if.slave    bus
);

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_CONV = 1'(CONV);

    localparam int SW = 4 * SCRATCH_DIGITS;
    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [0:0]    state_q;
    logic [15:0]   shreg_q;
    logic [SW-1:0] scratch_q;
    logic [SW-1:0] scratch_adj;
    logic [SW-1:0] scratch_nx;
    logic [4:0]    cnt_q;
    logic          accept;
    logic          done;

    logic [DW-1:0] disp_q;
    logic [DW-1:0] disp_d;
    logic          ovf_q;
    logic          ovf_d;

    logic [PW-1:0] presc_q;
    logic          wrap;
    logic [1:0]    idx_q;
    logic [1:0]    idx_d;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic          lead_blank;
    logic [3:0]    an_q;
    logic [3:0]    an_d;
    logic [6:0]    sseg_q;
    logic [6:0]    sseg_d;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    always_comb begin
        scratch_adj = '0;
        for (int i = 0; i < SCRATCH_DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
    end

    assign scratch_nx = {scratch_adj[SW-2:0], shreg_q[15]};
    assign accept     = (state_q == ST_IDLE) && bus.load;
    assign done       = (state_q == ST_CONV) && (cnt_q == 5'd15);

    assign disp_d = done ? scratch_nx[DW-1:0] : disp_q;
    assign ovf_d  = done ? (scratch_nx[SW-1:DW] != '0) : ovf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
            if (accept) begin
                state_q   <= ST_CONV;
                shreg_q   <= bus.in;
                scratch_q <= '0;
                cnt_q     <= '0;
            end else if (state_q == ST_CONV) begin
                scratch_q <= scratch_nx;
                shreg_q   <= {shreg_q[14:0], 1'b0};
                cnt_q     <= cnt_q + 5'd1;
                if (done) begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    // Scan outputs are registered from next-state values so they change
    // in the same cycle as the state they reflect, with no decode glitches.
    assign wrap      = (presc_q == PRESC_MAX);
    assign idx_d     = wrap ? idx_q + 2'd1 : idx_q;
    assign cur_digit = disp_d[{idx_d, 2'b00} +: 4];
    assign an_d      = ~(4'b0001 << idx_d);

    seg7_decode u_seg7_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign lead_blank = (idx_d != 2'd0) && ((disp_d >> {idx_d, 2'b00}) == '0);
`else
    assign lead_blank = 1'b0;
`endif

    always_comb begin
        sseg_d = dec_seg;
        if (ovf_d) begin
            sseg_d = SEG_DASH;
        end else if (lead_blank) begin
            sseg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1110;
            sseg_q  <= SEG_TABLE[0];
        end else begin
            presc_q <= wrap ? '0 : presc_q + PW'(1);
            idx_q   <= idx_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
        end
    end

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.ovf   = ovf_q;
    assign bus.an    = an_q;
    assign bus.sseg  = sseg_q;

endmodule

// File: tb/tb_bcd_display.sv
// tb/tb_bcd_display.sv - self-checking bench for bcd_display (honours LEADING_ZERO_BLANK_EN)
module tb_bcd_display;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bcd_display_if bus();

    bcd_display #(.CLK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              value;
        logic            ovf;
        logic [3:0][6:0] segs;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int k);
        int p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        if (v > 9999) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && v < p) return 7'b1111111;
`endif
        return ref_seg((v / p) % 10);
    endfunction

    function automatic logic [3:0][6:0] model_segs(input int v);
        logic [3:0][6:0] r;
        for (int k = 0; k < 4; k++) r[k] = model_seg(v, k);
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("wait_ready", 32'(bus.ready), 1);
    endtask

    task automatic start_load(input logic [15:0] v);
        bus.in   = v;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic run_conv(input logic [15:0] v, input int busy_at, input logic [15:0] busy_val);
        int lat = 0;
        wait_ready();
        start_load(v);
        while (bus.ready !== 1'b1 && lat < 40) begin
            lat++;
            if (lat == busy_at) begin
                bus.in   = busy_val;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        check($sformatf("ready_lat_%0d", v), lat, 16);
    endtask

    task automatic check_scan(input string tag, input logic [3:0][6:0] exp, input logic exp_ovf);
        int seen = 0;
        int not_ready = 0;
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        for (int c = 0; c < 16; c++) begin
            int idx = -1;
            for (int k = 0; k < 4; k++) begin
                if (bus.an == ~(4'b0001 << k)) idx = k;
            end
            if (idx < 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_an: got %b expected one-hot-low", tag, bus.an);
            end else begin
                seen = seen | (1 << idx);
                check($sformatf("%s_sseg_d%0d", tag, idx), 32'(bus.sseg), 32'(exp[idx]));
            end
            if (bus.ready !== 1'b1) not_ready++;
            @(negedge clk);
        end
        check({tag, "_digits_seen"}, seen, 15);
        check({tag, "_ready_hold"}, not_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in   = '0;
        bus.load = 1'b0;
        rst      = 1'b0;

        vecs[0] = '{1234,  1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{9999,  1'b0, {4{7'b0010000}}};
        vecs[2] = '{10000, 1'b1, {4{7'b0111111}}};
        vecs[3] = '{65535, 1'b1, {4{7'b0111111}}};
        vecs[4] = '{1000,  1'b0, {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[5] = '{0,     1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        vecs[6] = '{42,    1'b0, {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100}};
`else
        vecs[5] = '{0,     1'b0, {4{7'b1000000}}};
        vecs[6] = '{42,    1'b0, {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100}};
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_ready", 32'(bus.ready), 1);
        check("rst_ovf",   32'(bus.ovf),   0);
        check("rst_an",    32'(bus.an),    32'(4'b1110));
        check("rst_sseg",  32'(bus.sseg),  32'(7'b1000000));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scan_an_%0d", i), 32'(bus.an), 32'(4'(~(4'b0001 << (i / 4)))));
            @(negedge clk);
        end

        for (int i = 0; i < 7; i++) begin
            run_conv(16'(vecs[i].value), 0, 16'd0);
            check_scan($sformatf("vec%0d", vecs[i].value), vecs[i].segs, vecs[i].ovf);
        end

        run_conv(16'd42, 5, 16'd7);
        check_scan("busy_load", vecs[6].segs, 1'b0);

        run_conv(16'd1234, 16, 16'd7);
        check_scan("final_edge_load", vecs[0].segs, 1'b0);

        wait_ready();
        start_load(16'd1234);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_ready", 32'(bus.ready), 1);
        check("midrst_ovf",   32'(bus.ovf),   0);
        check("midrst_an",    32'(bus.an),    32'(4'b1110));
        check("midrst_sseg",  32'(bus.sseg),  32'(7'b1000000));
        check_scan("midrst_disp", model_segs(0), 1'b0);
        run_conv(16'd5, 0, 16'd0);
        check_scan("after_rst_5", model_segs(5), 1'b0);

        for (int r = 0; r < 24; r++) begin
            int v;
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 65535));
            else                           v = int'($urandom_range(0, 9999));
            run_conv(16'(v), 0, 16'd0);
            check_scan($sformatf("rand%0d", v), model_segs(v), v > 9999);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
